// File: rtl/conf_pkg.sv
// Shared constants for the option store: option indices, reset defaults,
// converter FSM encoding and the BCD digit clamp helper.
package conf_pkg;

   localparam int N_OPTS    = 5;
   localparam int OPT_DIT   = 0;
   localparam int OPT_DAH   = 1;
   localparam int OPT_WORD  = 2;
   localparam int OPT_TOL   = 3;
   localparam int OPT_PPU   = 4;
   localparam int DIG_CNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CONV,
      ST_COMMIT
   } conv_state_t;

   function automatic logic [23:0] bcd_default(input int idx);
      case (idx)
         OPT_DIT:  return 24'h000100;
         OPT_DAH:  return 24'h000300;
         OPT_WORD: return 24'h000700;
         OPT_TOL:  return 24'h000030;
         OPT_PPU:  return 24'h001000;
         default:  return 24'h000000;
      endcase
   endfunction

   function automatic logic [19:0] bin_default(input int idx);
      case (idx)
         OPT_DIT:  return 20'd100;
         OPT_DAH:  return 20'd300;
         OPT_WORD: return 20'd700;
         OPT_TOL:  return 20'd30;
         OPT_PPU:  return 20'd1000;
         default:  return 20'd0;
      endcase
   endfunction

   function automatic logic [3:0] clamp_digit(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

endpackage

// File: rtl/bcd_to_bin_serial.sv
// Serial BCD-to-binary converter: one digit per ce cycle, most significant first.
// done is high during the cycle that folds in the last digit; result then holds.
module bcd_to_bin_serial
   import conf_pkg::*;
#(
   parameter int UNIT_BCD_W = 6,
   parameter int BIN_W      = 20
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ce,
   input  logic                    start,
   input  logic [UNIT_BCD_W*4-1:0] bcd_in,
   output logic                    done,
   output logic [BIN_W-1:0]        result
);

   localparam int BCD_W = UNIT_BCD_W * 4;

   logic [BCD_W-1:0]     r_snap;
   logic [DIG_CNT_W-1:0] r_cnt;
   logic                 r_run;
   logic [BIN_W-1:0]     r_acc;
   logic [3:0]           w_digit;

   assign w_digit = r_snap[BCD_W-1 -: 4];
   assign done    = r_run && (r_cnt == DIG_CNT_W'(UNIT_BCD_W - 1));
   assign result  = r_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_snap <= '0;
         r_cnt  <= '0;
         r_run  <= 1'b0;
         r_acc  <= '0;
      end else if (ce) begin
         if (start) begin
            r_snap <= bcd_in;
            r_cnt  <= '0;
            r_run  <= 1'b1;
            r_acc  <= '0;
         end else if (r_run) begin
            // acc*10 + digit without a multiplier
            r_acc  <= (r_acc << 3) + (r_acc << 1) + BIN_W'(w_digit);
            r_snap <= r_snap << 4;
            r_cnt  <= r_cnt + 1'b1;
            if (done) r_run <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/conf_store.sv
// Option store: holds five BCD options, serves reads with one ce-cycle latency and
// re-converts dirty options to binary, committing each result atomically.
module conf_store
   import conf_pkg::*;
#(
   parameter int UNIT_BCD_W = 6,
   parameter int BIN_W      = 20
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ce,
   input  logic [2:0]              sel_index,
   output logic [UNIT_BCD_W*4-1:0] sel_value,
   input  logic [UNIT_BCD_W*4-1:0] sel_new_value,
   input  logic                    sel_set,
   output logic [BIN_W-1:0]        dit_units,
   output logic [BIN_W-1:0]        dah_units,
   output logic [BIN_W-1:0]        word_units,
   output logic [BIN_W-1:0]        tol_units,
   output logic [BIN_W-1:0]        ppu_units,
   output logic                    busy,
   output logic                    bin_valid
);

   localparam int SEL_W = UNIT_BCD_W * 4;

   logic [SEL_W-1:0]  r_store [N_OPTS];
   logic [BIN_W-1:0]  r_bin   [N_OPTS];
   logic [N_OPTS-1:0] r_dirty;
   logic [SEL_W-1:0]  r_sel_value;
   logic [2:0]        r_cur_idx;
   logic              r_busy;
   logic              r_bin_valid;
   conv_state_t       r_state;

   conv_state_t       w_state_nxt;
   logic [N_OPTS-1:0] w_dirty_nxt;
   logic [SEL_W-1:0]  w_clean;
   logic [SEL_W-1:0]  w_rd_value;
   logic [2:0]        w_pick;
   logic              w_set_ok;
   logic              w_start;
   logic              w_commit;
   logic              w_conv_done;
   logic [BIN_W-1:0]  w_result;

   assign w_set_ok = sel_set && (sel_index < 3'(N_OPTS));

   always_comb begin
      w_clean = '0;
      for (int d = 0; d < UNIT_BCD_W; d++)
         w_clean[4*d +: 4] = clamp_digit(sel_new_value[4*d +: 4]);
   end

   // A write is visible on the read port in the same cycle it lands
   always_comb begin
      w_rd_value = '0;
      if (w_set_ok)
         w_rd_value = w_clean;
      else if (sel_index < 3'(N_OPTS))
         w_rd_value = r_store[sel_index];
   end

   always_comb begin
      w_pick = 3'd0;
      for (int i = N_OPTS - 1; i >= 0; i--)
         if (r_dirty[i]) w_pick = 3'(i);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_dirty_nxt = r_dirty;
      w_start     = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE:   if (|r_dirty) w_state_nxt = ST_LOAD;
         ST_LOAD: begin
            w_start             = 1'b1;
            w_dirty_nxt[w_pick] = 1'b0;
            w_state_nxt         = ST_CONV;
         end
         ST_CONV:   if (w_conv_done) w_state_nxt = ST_COMMIT;
         ST_COMMIT: w_commit = 1'b1;
         default:   w_state_nxt = ST_IDLE;
      endcase
      // A same-cycle write overrides the LOAD clear so the option reconverts
      if (w_set_ok) w_dirty_nxt[sel_index] = 1'b1;
      if (r_state == ST_COMMIT)
         w_state_nxt = (|w_dirty_nxt) ? ST_LOAD : ST_IDLE;
   end

   bcd_to_bin_serial #(
      .UNIT_BCD_W (UNIT_BCD_W),
      .BIN_W      (BIN_W)
   ) u_conv (
      .clk    (clk),
      .rst_n  (rst_n),
      .ce     (ce),
      .start  (w_start),
      .bcd_in (r_store[w_pick]),
      .done   (w_conv_done),
      .result (w_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_OPTS; i++) begin
            r_store[i] <= SEL_W'(bcd_default(i));
            r_bin[i]   <= BIN_W'(bin_default(i));
         end
         r_dirty     <= '1;
         r_sel_value <= '0;
         r_cur_idx   <= 3'd0;
         r_busy      <= 1'b0;
         r_bin_valid <= 1'b0;
         r_state     <= ST_IDLE;
      end else if (ce) begin
         r_state     <= w_state_nxt;
         r_dirty     <= w_dirty_nxt;
         r_busy      <= (w_state_nxt != ST_IDLE);
         r_bin_valid <= (w_state_nxt == ST_IDLE) && (w_dirty_nxt == '0);
         r_sel_value <= w_rd_value;
         if (w_set_ok) r_store[sel_index] <= w_clean;
         if (w_start)  r_cur_idx <= w_pick;
         if (w_commit) r_bin[r_cur_idx] <= w_result;
      end
   end

   assign sel_value  = r_sel_value;
   assign busy       = r_busy;
   assign bin_valid  = r_bin_valid;
   assign dit_units  = r_bin[OPT_DIT];
   assign dah_units  = r_bin[OPT_DAH];
   assign word_units = r_bin[OPT_WORD];
   assign tol_units  = r_bin[OPT_TOL];
   assign ppu_units  = r_bin[OPT_PPU];

endmodule

// File: doc/conf_store.md
Name: conf_store

Overview:
Responder end of the option-edit interface driven by the menu controller. It holds the five BCD timing options (dit, dah, word gap, tolerance, pulses-per-unit), serves the selected option's value, and accepts overwrites. It continuously converts every changed option to binary with a serial converter, so the Morse timing logic receives atomic, glitch-free binary unit counts.

Parameters:
UNIT_BCD_W, 6, BCD digits per option
N_OPTS, 5, number of stored options
BIN_W, 20, binary output width (999999 < 2^20)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
ce  in  1  clock enable; all state holds when low
sel_index  in  3  option index from menu
sel_value  out  UNIT_BCD_W*4  registered BCD value of selected option
sel_new_value  in  UNIT_BCD_W*4  BCD value to write
sel_set  in  1  write strobe, sampled when ce=1
dit_units  out  BIN_W  binary option 0
dah_units  out  BIN_W  binary option 1
word_units  out  BIN_W  binary option 2
tol_units  out  BIN_W  binary option 3
ppu_units  out  BIN_W  binary option 4
busy  out  1  converter not idle
bin_valid  out  1  all binary outputs match stored BCD

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, rst_n.
- Reset: BCD store gets the package defaults (dit 000100, dah 000300, word 000700, tol 000030, ppu 001000). Binary outputs get the matching binary defaults. sel_value=0, all dirty bits=1, state IDLE, busy=0, bin_valid=0.
- Read: each ce cycle, sel_value <= store[sel_index], giving 1 ce-cycle latency. If sel_index>=N_OPTS, sel_value <= 0.
- Write: ce && sel_set && sel_index<N_OPTS writes the sanitized value to store[sel_index]. Sanitizing clamps every digit >9 to 9. The same cycle, sel_value <= the sanitized value (write-through). The write sets dirty[sel_index]. A set with index>=N_OPTS is ignored.
- Converter FSM, advancing only on ce:
  - IDLE: if any dirty bit is set, go to LOAD.
  - LOAD: pick the lowest dirty index, snapshot its BCD, clear its dirty bit, set acc=0.
  - CONV: 6 cycles, MSD first; acc <= (acc<<3)+(acc<<1)+digit.
  - COMMIT: write acc to that option's output register. Go to LOAD if any dirty bit remains, otherwise go to IDLE.
  - Each option takes 8 ce cycles from LOAD through COMMIT.
- Simultaneous set and LOAD on the same index: the set wins, so the dirty bit stays 1. The in-flight snapshot commits, then the option is reconverted.
- A set during CONV of the same option does not disturb the snapshot; that option reconverts afterwards.
- Binary outputs change only in COMMIT and never show partial values.
- busy = (state != IDLE), registered.
- bin_valid is registered. It is 1 only when state is IDLE and there are no dirty bits, and it falls in the same cycle a set is accepted.
- rst_n low at any point, including mid-conversion: immediate return to reset values. Nothing in flight survives.
- ce low: store, sel_value, FSM, acc and outputs all hold.

Decomposition:
- conf_pkg:
  - N_OPTS
  - option index constants (OPT_DIT=0 through OPT_PPU=4)
  - BCD defaults and binary defaults
  - FSM state encoding (IDLE/LOAD/CONV/COMMIT)
  - digit counter width
- Sub-module bcd_to_bin_serial:
  - Holds the snapshot register, digit counter and acc.
  - Controls: start, ce. Outputs: done, result.
- conf_store contains the store, dirty bits, read mux, FSM sequencing and output registers.

Test Plan:
1. Release reset, hold sel_index=0 -> sel_value=0x000100 after 1 ce cycle; dit_units=100 throughout; busy high; bin_valid=1 by ce cycle 41 and not before cycle 40.
2. After idle, sel_index=1, sel_new_value=0x000450, one-cycle sel_set -> sel_value=0x000450 next cycle; dah_units stays 300 until COMMIT, then 450 exactly 9 ce cycles after the set; bin_valid low over that window.
3. Write 0x00A0F3 to index 3 -> sel_value=0x009093; tol_units=9093.
4. Write index 2 = 0x000200, then 0x000250 three ce cycles later -> word_units shows 200 briefly, then ends at 250; bin_valid rises only after the second commit.
5. Hold ce low for 20 cycles during CONV of a write of 0x012345 to index 4 -> all outputs frozen; ppu_units=12345 after ce resumes.
6. Write index 3 = 0x000999, assert rst_n low mid-CONV -> tol_units=30 and sel_value=0 asynchronously; sel_index=5 read returns 0; sel_set at index 6 leaves all values unchanged.
